// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I multicycle core fetch stage.
package rv_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: one-cycle request pulse, response strobe later.
interface instr_fetch_if;
   import rv_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );

endinterface

// File: rtl/pc_register.sv
// Program counter: sequential +4 on capture, redirects, pending redirect and
// sticky misalignment flag.
module pc_register
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_idle_i,
   input  logic            capture_i,
   input  logic            load_i,
   input  logic [XLEN-1:0] target_i,
   output logic [XLEN-1:0] pc_o,
   output logic            misalign_o
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_q, pend_d;
   logic            pend_vld_q, pend_vld_d;
   logic            misalign_q, misalign_d;
   logic            aligned;

   assign aligned = (target_i[1:0] == 2'b00);

   // Next PC: capture advances (or applies the latest redirect), otherwise a
   // redirect hits the PC directly in IDLE or is parked until capture.
   always_comb begin
      pc_d       = pc_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      misalign_d = misalign_q;
      if (load_i && !aligned) begin
         misalign_d = 1'b1;
      end
      if (capture_i) begin
         // A redirect arriving on the capture edge is the most recent one.
         if (load_i && aligned) begin
            pc_d = target_i;
         end else if (pend_vld_q) begin
            pc_d = pend_q;
         end else begin
            pc_d = pc_q + 32'd4;
         end
         pend_vld_d = 1'b0;
      end else if (load_i && aligned) begin
         if (in_idle_i) begin
            pc_d = target_i;
         end else begin
            pend_d     = target_i;
            pend_vld_d = 1'b1;
         end
      end
   end

   // State update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         pend_q     <= RESET_PC;
         pend_vld_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc_o       = pc_q;
   assign misalign_o = misalign_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: fetch FSM, instruction register and PC.
module instr_fetch
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_en,
   input  logic             pc_load,
   input  logic [XLEN-1:0]  pc_next,
   instr_fetch_if.master    imem,
   output logic [XLEN-1:0]  instr,
   output logic             instr_valid,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_old,
   output logic             misalign_err
);

   fetch_state_t    state_q;
   logic            pend_fetch_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_old_q;
   logic            instr_valid_q;
   logic            capture;

   assign capture = (state_q == WAIT) && imem.imem_valid;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk        (clk),
      .reset      (reset),
      .in_idle_i  (state_q == IDLE),
      .capture_i  (capture),
      .load_i     (pc_load),
      .target_i   (pc_next),
      .pc_o       (pc),
      .misalign_o (misalign_err)
   );

   // Fetch FSM and instruction register; a redirect coinciding with fetch_en
   // in IDLE defers the request one cycle so it uses the new PC.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         pend_fetch_q  <= 1'b0;
         instr_q       <= NOP_INSTR;
         pc_old_q      <= RESET_PC;
         instr_valid_q <= 1'b0;
      end else begin
         instr_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pend_fetch_q || (fetch_en && !pc_load)) begin
                  state_q      <= REQ;
                  pend_fetch_q <= 1'b0;
               end else if (fetch_en && pc_load) begin
                  pend_fetch_q <= 1'b1;
               end
            end
            REQ: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (imem.imem_valid) begin
                  instr_q       <= imem.imem_rdata;
                  pc_old_q      <= pc;
                  instr_valid_q <= 1'b1;
                  state_q       <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign imem.imem_req  = (state_q == REQ);
   assign imem.imem_addr = pc;
   assign instr          = instr_q;
   assign instr_valid    = instr_valid_q;
   assign pc_old         = pc_old_q;

endmodule
